// File: rtl/gemm_insn_issue_if.sv
// Command/issue bundle between a GEMM command source and the gemm core.
// The slave modport is the issue block; the master modport is whoever drives commands and consumes insns.
`timescale 1ns/1ps
interface gemm_insn_issue_if #(
    parameter int INS_WIDTH = 128,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_opcode;
    logic [3:0]           cmd_dep;
    logic                 cmd_reset_reg;
    logic [12:0]          cmd_uop_bgn;
    logic [13:0]          cmd_uop_end;
    logic [13:0]          cmd_iter_out;
    logic [13:0]          cmd_iter_in;
    logic [10:0]          cmd_dst_fo;
    logic [10:0]          cmd_dst_fi;
    logic [10:0]          cmd_src_fo;
    logic [10:0]          cmd_src_fi;
    logic [9:0]           cmd_wgt_fo;
    logic [9:0]           cmd_wgt_fi;

    logic [INS_WIDTH-1:0] insn;
    logic                 insn_valid;
    logic                 insn_ready;

    logic                 cmd_err;
    logic [CW-1:0]        fifo_count;
    logic [CNT_WIDTH-1:0] issued_cnt;
    logic [CNT_WIDTH-1:0] err_cnt;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_dep, cmd_reset_reg, cmd_uop_bgn, cmd_uop_end,
               cmd_iter_out, cmd_iter_in, cmd_dst_fo, cmd_dst_fi, cmd_src_fo, cmd_src_fi,
               cmd_wgt_fo, cmd_wgt_fi, insn_ready,
        output cmd_ready, insn, insn_valid, cmd_err, fifo_count, issued_cnt, err_cnt
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_dep, cmd_reset_reg, cmd_uop_bgn, cmd_uop_end,
               cmd_iter_out, cmd_iter_in, cmd_dst_fo, cmd_dst_fi, cmd_src_fo, cmd_src_fi,
               cmd_wgt_fo, cmd_wgt_fi, insn_ready,
        input  cmd_ready, insn, insn_valid, cmd_err, fifo_count, issued_cnt, err_cnt
    );
endinterface

// File: rtl/gemm_insn_issue.sv
// Validates GEMM command fields, packs them into 128-bit insns and queues them in a
// DEPTH-entry FIFO whose head is offered to the gemm core.
`timescale 1ns/1ps
module gemm_insn_issue #(
    parameter int INS_WIDTH = 128,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    gemm_insn_issue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 cmd_err_q, cmd_err_d;
    logic [CNT_WIDTH-1:0] issued_cnt_q, issued_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [INS_WIDTH-1:0] mem_q [DEPTH];
    logic [INS_WIDTH-1:0] mem_d [DEPTH];

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 cmd_accept;
    logic                 cmd_reject;
    logic                 push;
    logic                 pop;
    logic [INS_WIDTH-1:0] pack_word;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    assign cmd_accept = bus.cmd_valid && !fifo_full;
    assign cmd_reject = (bus.cmd_opcode == 3'd2) &&
                        ((bus.cmd_uop_end <= {1'b0, bus.cmd_uop_bgn}) ||
                         (bus.cmd_iter_out == 14'd0) ||
                         (bus.cmd_iter_in == 14'd0));
    assign push       = cmd_accept && !cmd_reject;
    assign pop        = !fifo_empty && bus.insn_ready;

    assign pack_word = INS_WIDTH'({1'b0,
                                   bus.cmd_wgt_fi, bus.cmd_wgt_fo,
                                   bus.cmd_src_fi, bus.cmd_src_fo,
                                   bus.cmd_dst_fi, bus.cmd_dst_fo,
                                   bus.cmd_iter_in, bus.cmd_iter_out,
                                   bus.cmd_uop_end, bus.cmd_uop_bgn,
                                   bus.cmd_reset_reg, bus.cmd_dep, bus.cmd_opcode});

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cmd_err_d    = 1'b0;
        issued_cnt_d = issued_cnt_q;
        err_cnt_d    = err_cnt_q;
        mem_d        = mem_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = pack_word;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (issued_cnt_q != {CNT_WIDTH{1'b1}}) begin
                issued_cnt_d = issued_cnt_q + CNT_WIDTH'(1);
            end
        end

        // A rejected command is still consumed; it only leaves a pulse and a count behind.
        if (cmd_accept && cmd_reject) begin
            cmd_err_d = 1'b1;
            if (err_cnt_q != {CNT_WIDTH{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cmd_err_q    <= 1'b0;
            issued_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cmd_err_q    <= cmd_err_d;
            issued_cnt_q <= issued_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Storage needs no reset: emptiness is owned by the pointers and insn is gated below.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.cmd_ready  = !fifo_full;
    assign bus.insn_valid = !fifo_empty;
    assign bus.insn       = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.cmd_err    = cmd_err_q;
    assign bus.fifo_count = wr_ptr_q - rd_ptr_q;
    assign bus.issued_cnt = issued_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_gemm_insn_issue.sv
// Randomized scoreboard bench for gemm_insn_issue: the driver queues expected insns from a
// field-offset packing model, and a separate monitor checks every popped insn in order.
`timescale 1ns/1ps
module tb_gemm_insn_issue;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gemm_insn_issue_if #(.INS_WIDTH(128), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

    gemm_insn_issue #(.INS_WIDTH(128), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  dep;
        logic        rr;
        logic [12:0] ub;
        logic [13:0] ue;
        logic [13:0] io;
        logic [13:0] ii;
        logic [10:0] dfo;
        logic [10:0] dfi;
        logic [10:0] sfo;
        logic [10:0] sfi;
        logic [9:0]  wfo;
        logic [9:0]  wfi;
    } cmd_t;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] sb [$];
    int           pops = 0;
    int           rejs = 0;
    bit           exp_err = 1'b0;
    cmd_t         idle_cmd = '0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] sat(int n);
        return (n > CMAX) ? 128'(CMAX) : 128'(n);
    endfunction

    // Packing model: each field placed at its documented bit offset.
    function automatic logic [127:0] pack(cmd_t c);
        logic [127:0] p;
        p = '0;
        p |= 128'(c.op);
        p |= 128'(c.dep) << 3;
        p |= 128'(c.rr)  << 7;
        p |= 128'(c.ub)  << 8;
        p |= 128'(c.ue)  << 21;
        p |= 128'(c.io)  << 35;
        p |= 128'(c.ii)  << 49;
        p |= 128'(c.dfo) << 63;
        p |= 128'(c.dfi) << 74;
        p |= 128'(c.sfo) << 85;
        p |= 128'(c.sfi) << 96;
        p |= 128'(c.wfo) << 107;
        p |= 128'(c.wfi) << 117;
        return p;
    endfunction

    function automatic bit is_rej(cmd_t c);
        return (c.op == 3'd2) && ((int'(c.ue) <= int'(c.ub)) || (c.io == 14'd0) || (c.ii == 14'd0));
    endfunction

    function automatic cmd_t rand_valid();
        cmd_t c;
        c.op  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd2;
        c.dep = 4'($urandom);
        c.rr  = 1'($urandom);
        c.ub  = 13'($urandom);
        c.ue  = {1'b0, c.ub} + 14'($urandom_range(1, 100));
        c.io  = 14'($urandom_range(1, 16383));
        c.ii  = 14'($urandom_range(1, 16383));
        c.dfo = 11'($urandom);
        c.dfi = 11'($urandom);
        c.sfo = 11'($urandom);
        c.sfi = 11'($urandom);
        c.wfo = 10'($urandom);
        c.wfi = 10'($urandom);
        return c;
    endfunction

    function automatic cmd_t rand_any();
        cmd_t c;
        c = rand_valid();
        case ($urandom_range(0, 5))
            0:       c.ue = {1'b0, c.ub} - 14'($urandom_range(0, 3));
            1:       c.io = '0;
            2:       c.ii = '0;
            default: ;
        endcase
        return c;
    endfunction

    task automatic apply(input cmd_t c, input bit v, input bit rdy);
        bus.cmd_valid     = v;
        bus.cmd_opcode    = c.op;
        bus.cmd_dep       = c.dep;
        bus.cmd_reset_reg = c.rr;
        bus.cmd_uop_bgn   = c.ub;
        bus.cmd_uop_end   = c.ue;
        bus.cmd_iter_out  = c.io;
        bus.cmd_iter_in   = c.ii;
        bus.cmd_dst_fo    = c.dfo;
        bus.cmd_dst_fi    = c.dfi;
        bus.cmd_src_fo    = c.sfo;
        bus.cmd_src_fi    = c.sfi;
        bus.cmd_wgt_fo    = c.wfo;
        bus.cmd_wgt_fi    = c.wfi;
        bus.insn_ready    = rdy;
    endtask

    // One clock: drive at posedge+1, check state at negedge, decide what the next edge does.
    task automatic cycle(input cmd_t c, input bit v, input bit rdy);
        bit nerr;
        apply(c, v, rdy);
        @(negedge clk);
        chk("fifo_count", 128'(bus.fifo_count), 128'(sb.size()));
        chk("cmd_ready", 128'(bus.cmd_ready), 128'(sb.size() != DEPTH));
        chk("insn_valid", 128'(bus.insn_valid), 128'(sb.size() != 0));
        if (sb.size() != 0) chk("insn_head", bus.insn, sb[0]);
        chk("cmd_err", 128'(bus.cmd_err), 128'(exp_err));
        chk("issued_cnt", 128'(bus.issued_cnt), sat(pops));
        chk("err_cnt", 128'(bus.err_cnt), sat(rejs));
        nerr = 1'b0;
        if (v && sb.size() != DEPTH) begin
            if (is_rej(c)) begin
                rejs++;
                nerr = 1'b1;
            end else begin
                sb.push_back(pack(c));
            end
        end
        @(posedge clk);
        #1;
        exp_err = nerr;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && sb.size() != 0; i++) cycle(idle_cmd, 1'b0, 1'b1);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
        end
        bus.insn_ready = 1'b0;
    endtask

    task automatic do_reset();
        bus.cmd_valid  = 1'b0;
        bus.insn_ready = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_insn_valid", 128'(bus.insn_valid), 128'(0));
        chk("rst_insn", bus.insn, 128'(0));
        chk("rst_fifo_count", 128'(bus.fifo_count), 128'(0));
        chk("rst_cmd_err", 128'(bus.cmd_err), 128'(0));
        sb.delete();
        pops    = 0;
        rejs    = 0;
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 128'(bus.cmd_ready), 128'(1));
        chk("post_rst_issued", 128'(bus.issued_cnt), 128'(0));
        chk("post_rst_err", 128'(bus.err_cnt), 128'(0));
    endtask

    // Monitor: after the driver's negedge decision, check any insn the core takes at the next edge.
    initial begin
        logic [127:0] exp;
        forever begin
            @(negedge clk);
            #1;
            if (rst && bus.insn_valid && bus.insn_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got insn %0h expected none", bus.insn);
                end else begin
                    exp = sb.pop_front();
                    chk("pop_insn", bus.insn, exp);
                    pops++;
                    $display("pop %0d insn=%032h", pops, bus.insn);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t         c;
        logic [127:0] t1_exp;
        apply(idle_cmd, 1'b0, 1'b0);

        // Reset state and first-insn pack/latency
        do_reset();
        c     = '0;
        c.op  = 3'd2;
        c.dep = 4'b0100;
        c.ub  = 13'd1;
        c.ue  = 14'd2;
        c.io  = 14'd16;
        c.ii  = 14'd1;
        c.dfo = 11'd1;
        c.sfo = 11'd1;
        cycle(c, 1'b1, 1'b0);
        bus.cmd_valid = 1'b0;
        t1_exp = 128'h0000_0000_0020_0000_8002_0080_0040_0122;
        @(negedge clk);
        chk("t1_valid", 128'(bus.insn_valid), 128'(1));
        chk("t1_insn", bus.insn, t1_exp);
        @(posedge clk);
        #1;
        drain();

        // Fill, hold with a fifth command pending, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++) cycle(rand_valid(), 1'b1, 1'b0);
        c = rand_valid();
        for (int i = 0; i < 3; i++) cycle(c, 1'b1, 1'b0);
        bus.cmd_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("t2_issued", 128'(bus.issued_cnt), 128'(4));
        chk("t2_count", 128'(bus.fifo_count), 128'(0));
        @(posedge clk);
        #1;

        // Rejects, then an unchecked non-GEMM opcode
        do_reset();
        c    = rand_valid();
        c.op = 3'd2; c.ub = 13'd5; c.ue = 14'd5;
        cycle(c, 1'b1, 1'b0);
        c    = rand_valid();
        c.op = 3'd2; c.ii = 14'd0;
        cycle(c, 1'b1, 1'b0);
        cycle(idle_cmd, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_err_cnt", 128'(bus.err_cnt), 128'(2));
        chk("t3_err_low", 128'(bus.cmd_err), 128'(0));
        chk("t3_no_valid", 128'(bus.insn_valid), 128'(0));
        @(posedge clk);
        #1;
        c    = rand_valid();
        c.op = 3'd0; c.ue = 14'd0; c.io = 14'd0;
        cycle(c, 1'b1, 1'b0);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t3_enq", 128'(bus.fifo_count), 128'(1));
        @(posedge clk);
        #1;
        drain();

        // Concurrent push and pop at count 2 across pointer wrap
        do_reset();
        for (int i = 0; i < 2; i++) cycle(rand_valid(), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(rand_valid(), 1'b1, 1'b1);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t4_count", 128'(bus.fifo_count), 128'(2));
        @(posedge clk);
        #1;
        drain();

        // Reset with entries queued
        do_reset();
        for (int i = 0; i < 3; i++) cycle(rand_valid(), 1'b1, 1'b0);
        do_reset();

        // Issued counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) cycle(rand_valid(), 1'b1, 1'b1);
        bus.cmd_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("t6_issued_sat", 128'(bus.issued_cnt), 128'(15));
        @(posedge clk);
        #1;

        // Random traffic with rejects and backpressure
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(rand_any(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end
        bus.cmd_valid = 1'b0;
        drain();
        cycle(idle_cmd, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
